// File: rtl/arbiter_pkg.sv
// Shared types and default sizing for the hold/round-robin arbiter family.
package arbiter_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_MAX_HOLD = 16;

endpackage

// File: rtl/rr_mask_pick.sv
// Combinational winner picker: lowest set bit at or above start (round-robin),
// falling back to the lowest set bit overall (wrap-around, or fixed priority).
module rr_mask_pick
  import arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  input  logic [IDX_W-1:0] start,
  input  arb_mode_e        mode,
  output logic [WIDTH-1:0] gnt,
  output logic [IDX_W-1:0] idx
);

  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] masked;
  logic [WIDTH-1:0] src;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
      assign mask[gi] = (IDX_W'(gi) >= start);
    end
  endgenerate

  assign masked = req & mask;

  // An empty upper window means the scan wraps, which is the unmasked pick.
  assign src = ((mode == ARB_RR) && (|masked)) ? masked : req;
  assign gnt = src & (~src + WIDTH'(1));

  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (gnt[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/rr_hold_arb.sv
// Registered fixed-priority / round-robin arbiter with bounded burst ownership.
module rr_hold_arb
  import arbiter_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     mode_i,
  input  logic [WIDTH-1:0]         req_i,
  output logic [WIDTH-1:0]         gnt_o,
  output logic                     gnt_valid_o,
  output logic [$clog2(WIDTH)-1:0] gnt_id_o
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_SAT = (MAX_HOLD == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_HOLD);

  arb_state_e       state_reg;
  logic [WIDTH-1:0] gnt_reg;
  logic [IDX_W-1:0] gnt_id_reg;
  logic [IDX_W-1:0] ptr_reg;
  logic [CNT_W-1:0] hold_cnt_reg;

  logic             owner_req;
  logic             expired;
  logic             arb_edge;
  logic             exclude;
  logic [WIDTH-1:0] others;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  arb_mode_e        mode;

  assign mode      = arb_mode_e'(mode_i);
  assign owner_req = |(req_i & gnt_reg);
  assign expired   = (MAX_HOLD != 0) && (state_reg == OWN) && (hold_cnt_reg == HOLD_SAT);
  assign arb_edge  = (state_reg == IDLE) || !owner_req || expired;

  // On expiry the owner steps aside only if someone else is actually waiting.
  assign others  = req_i & ~gnt_reg;
  assign exclude = expired && (|others);
  assign cand    = exclude ? others : req_i;

  rr_mask_pick #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (cand),
    .start (ptr_reg),
    .mode  (mode),
    .gnt   (pick_gnt),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      gnt_reg      <= '0;
      gnt_id_reg   <= '0;
      ptr_reg      <= '0;
      hold_cnt_reg <= '0;
    end else if (arb_edge) begin
      if (|cand) begin
        state_reg    <= OWN;
        gnt_reg      <= pick_gnt;
        gnt_id_reg   <= pick_idx;
        hold_cnt_reg <= CNT_W'(1);
        if (mode == ARB_RR) begin
          ptr_reg <= (pick_idx == IDX_W'(WIDTH - 1)) ? '0 : pick_idx + IDX_W'(1);
        end
      end else begin
        state_reg    <= IDLE;
        gnt_reg      <= '0;
        gnt_id_reg   <= '0;
        hold_cnt_reg <= '0;
      end
    end else if (hold_cnt_reg != HOLD_SAT) begin
      hold_cnt_reg <= hold_cnt_reg + CNT_W'(1);
    end
  end

  assign gnt_o       = gnt_reg;
  assign gnt_valid_o = |gnt_reg;
  assign gnt_id_o    = gnt_id_reg;

endmodule

// File: tb/tb_rr_hold_arb.sv
// Randomized + directed bench for rr_hold_arb (WIDTH=4) at MAX_HOLD=4 and MAX_HOLD=1.
module tb_rr_hold_arb;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       mode_i;
  logic [3:0] req_i;

  logic [3:0] gnt_a, gnt_b;
  logic       vld_a, vld_b;
  logic [1:0] id_a, id_b;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: owner index (-1 = none), burst length, round-robin pointer.
  int own[2];
  int cnt[2];
  int ptr[2];
  int mh[2] = '{4, 1};

  always #5 clk_i = ~clk_i;

  rr_hold_arb #(.WIDTH(4), .MAX_HOLD(4)) dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .mode_i(mode_i), .req_i(req_i),
    .gnt_o(gnt_a), .gnt_valid_o(vld_a), .gnt_id_o(id_a)
  );

  rr_hold_arb #(.WIDTH(4), .MAX_HOLD(1)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .mode_i(mode_i), .req_i(req_i),
    .gnt_o(gnt_b), .gnt_valid_o(vld_b), .gnt_id_o(id_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic m, input logic [3:0] q);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        own[k] = -1; cnt[k] = 0; ptr[k] = 0;
      end else if (own[k] >= 0 && q[own[k]] && cnt[k] != mh[k]) begin
        cnt[k] = cnt[k] + 1;
      end else begin
        logic [3:0] c;
        int w;
        c = q;
        if (own[k] >= 0 && cnt[k] == mh[k] && (q & ~(4'b0001 << own[k])) != 4'b0000)
          c[own[k]] = 1'b0;
        w = -1;
        for (int s = 0; s < 4; s++) begin
          int i;
          i = m ? (ptr[k] + s) % 4 : s;
          if (w < 0 && c[i]) w = i;
        end
        if (w >= 0) begin
          own[k] = w; cnt[k] = 1;
          if (m) ptr[k] = (w + 1) % 4;
        end else begin
          own[k] = -1; cnt[k] = 0;
        end
      end
    end
  endtask

  function automatic logic [3:0] exp_gnt(input int o);
    return (o < 0) ? 4'b0000 : 4'(1 << o);
  endfunction

  task automatic step(input logic r, input logic m, input logic [3:0] q, input string ph);
    rst_i = r; mode_i = m; req_i = q;
    @(posedge clk_i);
    model_edge(r, m, q);
    #1;
    check({ph, "/gnt_h4"}, 32'(gnt_a), 32'(exp_gnt(own[0])));
    check({ph, "/vld_h4"}, 32'(vld_a), 32'(own[0] >= 0));
    check({ph, "/id_h4"},  32'(id_a),  32'((own[0] < 0) ? 0 : own[0]));
    check({ph, "/gnt_h1"}, 32'(gnt_b), 32'(exp_gnt(own[1])));
    check({ph, "/vld_h1"}, 32'(vld_b), 32'(own[1] >= 0));
    check({ph, "/id_h1"},  32'(id_b),  32'((own[1] < 0) ? 0 : own[1]));
    $display("%-6s rst=%b mode=%b req=%b | h4 gnt=%b id=%0d | h1 gnt=%b id=%0d",
             ph, r, m, q, gnt_a, id_a, gnt_b, id_b);
  endtask

  initial begin
    logic       r, m;
    logic [3:0] q;
    own = '{-1, -1}; cnt = '{0, 0}; ptr = '{0, 0};
    rst_i = 1'b1; mode_i = 1'b0; req_i = 4'b0000;

    // Reset holds outputs low regardless of requests, then grants 0001.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'b1111, "rst");
    step(1'b0, 1'b1, 4'b1111, "rel");
    check("rel/first", 32'(gnt_a), 32'h1);

    // Fixed priority with hold expiry rotating 1010.
    step(1'b1, 1'b0, 4'b0000, "rst");
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 4'b1010, "fix");

    // Round-robin sweep over all requesters.
    step(1'b1, 1'b1, 4'b0000, "rst");
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 4'b1111, "rr");

    // Release hand-off without an idle bubble.
    step(1'b1, 1'b1, 4'b0000, "rst");
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 4'b0111, "hand");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'b0101, "hand");

    // Single requester re-granted across expiry, then dropped.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 4'b0100, "solo");
    step(1'b0, 1'b0, 4'b0000, "drop");
    check("drop/idle", 32'(gnt_a), 32'h0);

    // Reset mid-ownership restores pointer 0.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'b1000, "own3");
    step(1'b1, 1'b1, 4'b1111, "mrst");
    step(1'b0, 1'b1, 4'b1111, "mrst");
    check("mrst/ptr0", 32'(gnt_a), 32'h1);

    // Random traffic with mode switches, bursts and occasional resets.
    m = 1'b0; q = 4'b0000;
    for (int i = 0; i < 500; i++) begin
      r = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 9) == 0) m = ~m;
      if ($urandom_range(0, 3) == 0) q = 4'($urandom_range(0, 15));
      step(r, m, q, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
